// File: rtl/dff_mem_cmd_ctrl_if.sv
// Host pin and memory-core signal bundle for the DFF memory command front-end.
// slave = the controller, master = the pins/memory side driving it.
interface dff_mem_cmd_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ena;
  logic [7:0]        host_data;
  logic              host_strobe;
  logic [7:0]        host_rdata;
  logic              host_busy;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ena, host_data, host_strobe, mem_ack, mem_rdata,
    output host_rdata, host_busy, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ena, host_data, host_strobe, mem_ack, mem_rdata,
    input  host_rdata, host_busy, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dff_mem_cmd_ctrl.sv
// Host command front-end for the DFF memory: strobe sync, command decode, req/ack to the core.
// Optional burst support (1..4 transfers, address wrap) is built when DFF_MEM_BURST_EN is defined.
module dff_mem_cmd_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  dff_mem_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_REQ   = 2'd2,
    ST_NEXT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1, r_sync2, r_prev;
  logic              w_evt;
  logic              w_last;
  logic              r_mem_req, r_mem_we, r_host_busy, r_err;
  logic              w_mem_req_nxt, w_mem_we_nxt, w_err_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]        r_host_rdata, w_host_rdata_nxt;
  logic              w_unused_host;

`ifdef DFF_MEM_BURST_EN
  logic [1:0]        r_cnt, w_cnt_nxt;
  assign w_last = (r_cnt == 2'd0);
`else
  assign w_last = 1'b1;
`endif

  // Not every command bit is decoded in every configuration.
  assign w_unused_host = ^bus.host_data;

  // Two-flop strobe synchroniser plus edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.host_strobe;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_evt = r_sync2 & ~r_prev & bus.ena;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_state_nxt = bus.host_data[7] ? ST_WDATA : ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WDATA, ST_NEXT: begin
        if (w_evt) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          w_state_nxt = w_last ? ST_IDLE : ST_NEXT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: next values of the registered bus outputs.
  always_comb begin
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_host_rdata_nxt = r_host_rdata;
    w_err_nxt        = r_err;
`ifdef DFF_MEM_BURST_EN
    w_cnt_nxt        = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_mem_addr_nxt = bus.host_data[ADDR_W-1:0];
          w_mem_we_nxt   = 1'b0;
`ifdef DFF_MEM_BURST_EN
          w_cnt_nxt      = bus.host_data[6] ? bus.host_data[5:4] : 2'd0;
`else
          // Burst requested but not built: flag it and run a single transfer.
          w_err_nxt      = r_err | bus.host_data[6];
`endif
        end else begin
          w_mem_addr_nxt = r_mem_addr;
        end
      end
      ST_WDATA: begin
        if (w_evt) begin
          w_mem_wdata_nxt = bus.host_data;
          w_mem_we_nxt    = 1'b1;
        end else begin
          w_mem_wdata_nxt = r_mem_wdata;
        end
      end
      ST_REQ: begin
        if (w_evt) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        if (bus.mem_ack && !r_mem_we) begin
          w_host_rdata_nxt = bus.mem_rdata;
        end else begin
          w_host_rdata_nxt = r_host_rdata;
        end
      end
      ST_NEXT: begin
        if (w_evt) begin
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
`ifdef DFF_MEM_BURST_EN
          w_cnt_nxt      = r_cnt - 2'd1;
`endif
          if (r_mem_we) begin
            w_mem_wdata_nxt = bus.host_data;
          end else begin
            w_mem_wdata_nxt = r_mem_wdata;
          end
        end else begin
          w_mem_addr_nxt = r_mem_addr;
        end
      end
      default: w_err_nxt = r_err;
    endcase
    if (w_state_nxt == ST_REQ) begin
      w_mem_req_nxt = 1'b1;
    end else begin
      w_mem_req_nxt = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req    <= 1'b0;
      r_host_busy  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_host_rdata <= 8'h00;
      r_err        <= 1'b0;
`ifdef DFF_MEM_BURST_EN
      r_cnt        <= 2'd0;
`endif
    end else begin
      r_mem_req    <= w_mem_req_nxt;
      r_host_busy  <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_host_rdata <= w_host_rdata_nxt;
      r_err        <= w_err_nxt;
`ifdef DFF_MEM_BURST_EN
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.host_busy  = r_host_busy;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.host_rdata = r_host_rdata;
  assign bus.err        = r_err;

endmodule
